uart_frame_parser: RTL and testbench

- Consumes the byte stream from the UART receiver: its one-cycle data-valid strobe plus the received byte.
- Frames packets of the form SOF, LEN, LEN payload bytes, XOR checksum. Validates length, checksum and inter-byte timing.
- Buffers the payload and replays it on a valid/ready byte stream to the command logic downstream.
- Reports frame completion and errors as single-cycle pulses.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_frame_buf.sv | 26 ++
 rtl/uart_frame_parser.sv | 170 +++++++++++++++++
 tb/tb_uart_frame_parser.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame parser: FSM states, error codes, default SOF.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StPayload,
        StCheck,
        StDrain
    } state_e;

    localparam logic [1:0] ERR_LEN     = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one write port, combinational read port, no reset.
module uart_frame_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[raddr[IW-1:0]];

endmodule

// File: rtl/uart_frame_parser.sv
// Frames SOF/LEN/payload/XOR-checksum packets from a UART byte strobe, checks length, checksum
// and inter-byte timeout, then replays the buffered payload on a valid/ready stream.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE     = SOF_BYTE_DEFAULT,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_CLKS = 8700
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_FIRE = TW'(TIMEOUT_CLKS - 2);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CLKS - 1);

    state_e        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          buf_we;
    logic [7:0]    buf_rdata;
    logic          timing;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (LW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx_q),
        .wdata (rx_byte),
        .raddr (idx_q),
        .rdata (buf_rdata)
    );

    assign timing = (state_q == StLen) || (state_q == StPayload) || (state_q == StCheck);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        tmo_d   = tmo_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        buf_we  = 1'b0;

        if (!timing || rx_valid) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            StIdle: begin
                idx_d  = '0;
                csum_d = '0;
                if (rx_valid && rx_byte == SOF_BYTE) begin
                    state_d = StLen;
                end
            end
            StLen: begin
                if (rx_valid) begin
                    if (rx_byte == 8'd0 || 32'(rx_byte) > MAX_LEN) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = StIdle;
                    end else begin
                        len_d   = rx_byte[LW-1:0];
                        csum_d  = rx_byte;
                        idx_d   = '0;
                        state_d = StPayload;
                    end
                end
            end
            StPayload: begin
                if (rx_valid) begin
                    buf_we = 1'b1;
                    csum_d = csum_q ^ rx_byte;
                    idx_d  = idx_q + LW'(1);
                    if (idx_d == len_q) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (rx_valid) begin
                    if (rx_byte == csum_q) begin
                        ok_d    = 1'b1;
                        idx_d   = '0;
                        state_d = StDrain;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CSUM;
                        state_d = StIdle;
                    end
                end
            end
            StDrain: begin
                // Incoming bytes cannot be buffered while draining; flag and drop them.
                if (rx_valid) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
                if (out_ready) begin
                    if (idx_q == len_q - LW'(1)) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A strobe in the expiry cycle wins, so only fire when no byte arrived.
        if (timing && !rx_valid && tmo_q == TMO_FIRE) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_LEN;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign out_valid = (state_q == StDrain);
    assign out_data  = out_valid ? buf_rdata : 8'd0;
    assign out_last  = out_valid && (idx_q == len_q - LW'(1));
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: expected payload bytes are queued as frames are sent.
module tb_uart_frame_parser;
    import uart_pkg::*;

    localparam int unsigned TimeoutClks = 8700;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    uart_frame_parser #(
        .SOF_BYTE     (8'hA5),
        .MAX_LEN      (16),
        .TIMEOUT_CLKS (TimeoutClks)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         ok_cnt = 0;
    int         err_cnt = 0;
    int         vcnt = 0;
    int         err_cyc = 0;
    logic [1:0] last_code = 2'd0;
    logic [8:0] exp_q[$];
    int         xfer_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, want);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: pulse counting and scoreboard comparison, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_ok) begin
                ok_cnt++;
                check("ok_with_valid", 32'(out_valid), 32'd1);
            end
            if (frame_err) begin
                err_cnt++;
                last_code = err_code;
                err_cyc = cyc;
            end
            if (out_valid) begin
                vcnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q[0][7:0]));
                    check("out_last", 32'(out_last), 32'(exp_q[0][8]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        xfer_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_good(input int n, input logic [7:0] base);
        logic [7:0] cs;
        logic [7:0] p;
        cs = 8'(n);
        send(8'hA5);
        send(8'(n));
        for (int i = 0; i < n; i++) begin
            p = base + 8'(i * 17);
            exp_q.push_back({(i == n - 1), p});
            cs = cs ^ p;
            send(p);
        end
        send(cs);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 32'(n < 64), 32'd1);
        exp_q.delete();
    endtask

    int ok0, e0, v0, c0, n;
    int pat[5] = '{1, 0, 0, 1, 1};

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_byte = 8'd0;
        out_ready = 1'b1;
        idle(3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_frame_ok", 32'(frame_ok), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        idle(2);

        // Good frame, always ready.
        xfer_cyc.delete();
        ok0 = ok_cnt; e0 = err_cnt;
        send_good(3, 8'h11);
        wait_drain();
        check("good_ok", 32'(ok_cnt - ok0), 32'd1);
        check("good_no_err", 32'(err_cnt - e0), 32'd0);
        check("good_xfers", 32'(xfer_cyc.size()), 32'd3);
        if (xfer_cyc.size() == 3) check("good_back2back", 32'(xfer_cyc[2] - xfer_cyc[0]), 32'd2);

        // Same frame with stalls.
        xfer_cyc.delete();
        ok0 = ok_cnt;
        send_good(3, 8'h11);
        for (int i = 0; i < 5; i++) begin
            out_ready = pat[i][0];
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        check("stall_idle_after_last", 32'(out_valid), 32'd0);
        wait_drain();
        check("stall_ok", 32'(ok_cnt - ok0), 32'd1);
        check("stall_xfers", 32'(xfer_cyc.size()), 32'd3);
        if (xfer_cyc.size() == 3) begin
            check("stall_gap0", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd3);
            check("stall_gap1", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd1);
        end

        // Checksum error: expected 0x32, sent 0xFF.
        e0 = err_cnt; v0 = vcnt; ok0 = ok_cnt;
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'hFF);
        idle(3);
        check("csum_err", 32'(err_cnt - e0), 32'd1);
        check("csum_code", 32'(last_code), 32'(ERR_CSUM));
        check("csum_no_valid", 32'(vcnt - v0), 32'd0);
        check("csum_no_ok", 32'(ok_cnt - ok0), 32'd0);

        // Length errors then a good frame.
        e0 = err_cnt;
        send(8'hA5); send(8'h00);
        idle(2);
        check("len0_err", 32'(err_cnt - e0), 32'd1);
        check("len0_code", 32'(last_code), 32'(ERR_LEN));
        e0 = err_cnt;
        send(8'hA5); send(8'h11);
        idle(2);
        check("len17_err", 32'(err_cnt - e0), 32'd1);
        check("len17_code", 32'(last_code), 32'(ERR_LEN));
        ok0 = ok_cnt;
        send_good(16, 8'h3C);
        wait_drain();
        check("len_recover_ok", 32'(ok_cnt - ok0), 32'd1);

        // Inter-byte timeout.
        e0 = err_cnt;
        send(8'hA5); send(8'h03); send(8'h11);
        c0 = cyc;
        n = 0;
        while (err_cnt == e0 && n < int'(TimeoutClks) + 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tmo_err", 32'(err_cnt - e0), 32'd1);
        check("tmo_code", 32'(last_code), 32'(ERR_TIMEOUT));
        check("tmo_latency", 32'(err_cyc - c0), TimeoutClks - 1);
        ok0 = ok_cnt;
        send_good(2, 8'h07);
        wait_drain();
        check("tmo_recover_ok", 32'(ok_cnt - ok0), 32'd1);

        // Overrun while stalled in drain.
        out_ready = 1'b0;
        e0 = err_cnt; ok0 = ok_cnt;
        send_good(4, 8'h21);
        send(8'h5A);
        idle(3);
        check("ovr_err", 32'(err_cnt - e0), 32'd1);
        check("ovr_code", 32'(last_code), 32'(ERR_OVERRUN));
        check("ovr_held", 32'(exp_q.size()), 32'd4);
        out_ready = 1'b1;
        wait_drain();
        check("ovr_ok", 32'(ok_cnt - ok0), 32'd1);

        // Reset mid-payload, then garbage, then a good frame.
        send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
        rst = 1'b1;
        idle(1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_frame_err", 32'(frame_err), 32'd0);
        check("mid_rst_frame_ok", 32'(frame_ok), 32'd0);
        check("mid_rst_err_code", 32'(err_code), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        e0 = err_cnt; v0 = vcnt;
        send(8'h03); send(8'h04); send(8'h05);
        idle(3);
        check("garbage_no_err", 32'(err_cnt - e0), 32'd0);
        check("garbage_no_valid", 32'(vcnt - v0), 32'd0);
        ok0 = ok_cnt;
        send_good(4, 8'h40);
        wait_drain();
        check("post_rst_ok", 32'(ok_cnt - ok0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
